// File: rtl/rvfi_retire_checker.sv
// Purpose: RVFI retirement stream checker (lane packing, order, PC chain, post-halt silence).
// Latency: every output is registered; a violation seen at edge N appears on err after edge N.
// Backpressure: none; this is a passive monitor that samples every lane on every clock.
module rvfi_retire_checker #(
    parameter int NRET    = 1,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET-1:0]         rvfi_trap,
    input  logic [NRET-1:0]         rvfi_halt,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [ORDER_W-1:0]      err_order,
    output logic [CNT_W-1:0]        retire_count,
    output logic                    halted
);

    // Rank counter must hold 0..NRET, so it also serves as the per-cycle retire count.
    localparam int KW    = $clog2(NRET + 1);
    localparam int SUM_W = ((CNT_W > KW) ? CNT_W : KW) + 1;

    localparam logic [2:0] CODE_NONE      = 3'd0;
    localparam logic [2:0] CODE_GAP       = 3'd1;
    localparam logic [2:0] CODE_ORDER     = 3'd2;
    localparam logic [2:0] CODE_PC        = 3'd3;
    localparam logic [2:0] CODE_POST_HALT = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Architectural checker state.
    logic               err_q,          err_d;
    logic [2:0]         err_code_q,     err_code_d;
    logic [ORDER_W-1:0] err_order_q,    err_order_d;
    logic [CNT_W-1:0]   retire_count_q, retire_count_d;
    logic               halted_q,       halted_d;
    logic [ORDER_W-1:0] exp_order_q,    exp_order_d;
    logic [XLEN-1:0]    exp_pc_q,       exp_pc_d;
    logic               exp_pc_valid_q, exp_pc_valid_d;

    // Results of the lane walk.
    logic [KW-1:0]      rank;
    logic               hole_seen;
    logic [XLEN-1:0]    pc_chain;
    logic               pc_known;
    logic               halt_seen;
    logic [2:0]         lane_code;
    logic               fail;
    logic [2:0]         fail_code;
    logic [ORDER_W-1:0] fail_order;
    logic [SUM_W-1:0]   cnt_sum;

    // Walk lanes in index order; the first offending lane wins, and within it the lowest code.
    always_comb begin
        rank       = '0;
        hole_seen  = 1'b0;
        pc_chain   = exp_pc_q;
        pc_known   = exp_pc_valid_q;
        halt_seen  = halted_q;
        lane_code  = CODE_NONE;
        fail       = 1'b0;
        fail_code  = CODE_NONE;
        fail_order = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_code = CODE_NONE;
            if (rvfi_valid[i]) begin
                // Tested from highest code down so the lowest applicable code is left standing.
                if (halt_seen) begin
                    lane_code = CODE_POST_HALT;
                end
                if (pc_known && (rvfi_pc_rdata[i*XLEN +: XLEN] != pc_chain)) begin
                    lane_code = CODE_PC;
                end
                if (rvfi_order[i*ORDER_W +: ORDER_W] != (exp_order_q + ORDER_W'(rank))) begin
                    lane_code = CODE_ORDER;
                end
                if (hole_seen) begin
                    lane_code = CODE_GAP;
                end
                if (!fail && (lane_code != CODE_NONE)) begin
                    fail       = 1'b1;
                    fail_code  = lane_code;
                    fail_order = (lane_code == CODE_GAP) ? exp_order_q
                                                         : (exp_order_q + ORDER_W'(rank));
                end
                // A trap redirects to an unchecked handler, so the next PC is unknown.
                pc_chain = rvfi_pc_wdata[i*XLEN +: XLEN];
                pc_known = !rvfi_trap[i];
                if (rvfi_halt[i]) begin
                    halt_seen = 1'b1;
                end
                rank = rank + KW'(1);
            end else begin
                hole_seen = 1'b1;
            end
        end
    end

    // Fold this cycle's lane walk into the next register state.
    always_comb begin
        err_d          = err_q | fail;
        err_code_d     = err_code_q;
        err_order_d    = err_order_q;
        if (fail && !err_q) begin
            err_code_d  = fail_code;
            err_order_d = fail_order;
        end
        exp_order_d    = exp_order_q + ORDER_W'(rank);
        cnt_sum        = SUM_W'(retire_count_q) + SUM_W'(rank);
        retire_count_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        halted_d       = halt_seen;
        exp_pc_d       = pc_chain;
        exp_pc_valid_d = pc_known;
    end

    // State registers; reset clears everything at once, so order 0 is expected next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q          <= 1'b0;
            err_code_q     <= CODE_NONE;
            err_order_q    <= '0;
            retire_count_q <= '0;
            halted_q       <= 1'b0;
            exp_order_q    <= '0;
            exp_pc_q       <= '0;
            exp_pc_valid_q <= 1'b0;
        end else begin
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            err_order_q    <= err_order_d;
            retire_count_q <= retire_count_d;
            halted_q       <= halted_d;
            exp_order_q    <= exp_order_d;
            exp_pc_q       <= exp_pc_d;
            exp_pc_valid_q <= exp_pc_valid_d;
        end
    end

    assign err          = err_q;
    assign err_code     = err_code_q;
    assign err_order    = err_order_q;
    assign retire_count = retire_count_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_rvfi_retire_checker.sv
// Purpose: self-checking bench for rvfi_retire_checker against a queue-based stream model.
// Latency: outputs compared half a clock after every active edge (and just after async reset).
// Backpressure: not applicable; stimulus is driven freely every cycle.
module tb_rvfi_retire_checker;

    localparam int NRET = 3;
    localparam int XLEN = 32;
    localparam int OW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*OW-1:0]   rvfi_order;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET-1:0]      rvfi_halt;
    logic [NRET*XLEN-1:0] rvfi_pc_rdata;
    logic [NRET*XLEN-1:0] rvfi_pc_wdata;
    logic                 err;
    logic [2:0]           err_code;
    logic [OW-1:0]        err_order;
    logic [CW-1:0]        retire_count;
    logic                 halted;

    rvfi_retire_checker #(.NRET(NRET), .XLEN(XLEN), .ORDER_W(OW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rvfi_valid   (rvfi_valid),
        .rvfi_order   (rvfi_order),
        .rvfi_trap    (rvfi_trap),
        .rvfi_halt    (rvfi_halt),
        .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata),
        .err          (err),
        .err_code     (err_code),
        .err_order    (err_order),
        .retire_count (retire_count),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Reference model state: the stream as the spec describes it.
    bit          m_err;
    int          m_code;
    int          m_eorder;
    int          m_cnt;
    bit          m_halted;
    int          m_exp;
    bit          m_known;
    logic [31:0] m_pc;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_code = 0; m_eorder = 0; m_cnt = 0;
        m_halted = 0; m_exp = 0; m_known = 0; m_pc = '0;
    endtask

    // One retirement cycle: rank the valid lanes, find the first offender, then advance the stream.
    task automatic model_step();
        int          vl[$];
        int          fl;
        int          fc;
        int          fo;
        bit          hb;
        bit          kn;
        logic [31:0] pc;
        fl = -1; fc = 0; fo = 0;
        hb = m_halted; kn = m_known; pc = m_pc;
        for (int i = 0; i < NRET; i++) if (rvfi_valid[i]) vl.push_back(i);
        for (int p = 0; p < vl.size(); p++) begin
            int ln;
            int want;
            int c;
            ln   = vl[p];
            want = (m_exp + p) % 256;
            c    = 0;
            if (ln != p)                                               c = 1;
            else if (int'(rvfi_order[ln*OW +: OW]) != want)            c = 2;
            else if (kn && rvfi_pc_rdata[ln*XLEN +: XLEN] != pc)       c = 3;
            else if (hb)                                               c = 4;
            if (fl < 0 && c != 0) begin
                fl = ln;
                fc = c;
                fo = (c == 1) ? m_exp : want;
            end
            pc = rvfi_pc_wdata[ln*XLEN +: XLEN];
            kn = !rvfi_trap[ln];
            if (rvfi_halt[ln]) hb = 1;
        end
        if (fl >= 0 && !m_err) begin
            m_code   = fc;
            m_eorder = fo;
        end
        if (fl >= 0) m_err = 1;
        m_exp    = (m_exp + vl.size()) % 256;
        m_cnt    = (m_cnt + vl.size() > CMAX) ? CMAX : m_cnt + vl.size();
        m_halted = hb;
        m_known  = kn;
        m_pc     = pc;
    endtask

    task automatic compare_model();
        chk("err",          64'(err),          64'(m_err));
        chk("err_code",     64'(err_code),     64'(m_code));
        chk("err_order",    64'(err_order),    64'(m_eorder));
        chk("retire_count", 64'(retire_count), 64'(m_cnt));
        chk("halted",       64'(halted),       64'(m_halted));
    endtask

    task automatic clear_inputs();
        rvfi_valid = '0; rvfi_order = '0; rvfi_trap = '0; rvfi_halt = '0;
        rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    endtask

    task automatic set_lane(input int i, input int ord, input bit trap, input bit halt,
                            input logic [31:0] r, input logic [31:0] w);
        rvfi_valid[i]                = 1'b1;
        rvfi_order[i*OW +: OW]       = OW'(ord);
        rvfi_trap[i]                 = trap;
        rvfi_halt[i]                 = halt;
        rvfi_pc_rdata[i*XLEN +: XLEN] = r;
        rvfi_pc_wdata[i*XLEN +: XLEN] = w;
    endtask

    // Inputs are applied at a falling edge; the model steps with the DUT at the rising edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // A fully legal cycle of k retires continuing the model's stream.
    task automatic legal_cycle(input int k);
        bit          kn;
        logic [31:0] pc;
        logic [31:0] r;
        kn = m_known; pc = m_pc;
        for (int p = 0; p < k; p++) begin
            r = kn ? pc : ($urandom & 32'hFFFF_FFFC);
            set_lane(p, m_exp + p, 1'b0, 1'b0, r, r + 32'd4);
            pc = r + 32'd4;
            kn = 1;
        end
        step();
    endtask

    // Random cycle: legal lanes with occasional traps/halts, junk on idle lanes, rare injected faults.
    task automatic random_cycle();
        int          k;
        int          e;
        int          ln;
        bit          kn;
        logic [31:0] pc;
        logic [31:0] r;
        logic [31:0] w;
        k  = $urandom_range(0, NRET);
        kn = m_known; pc = m_pc;
        for (int p = 0; p < NRET; p++) begin
            if (p < k) begin
                r = kn ? pc : ($urandom & 32'hFFFF_FFFC);
                w = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : r + 32'd4;
                set_lane(p, m_exp + p, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, r, w);
                pc = w;
                kn = !rvfi_trap[p];
            end else begin
                set_lane(p, int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), $urandom, $urandom);
                rvfi_valid[p] = 1'b0;
            end
        end
        e  = $urandom_range(0, 24);
        ln = $urandom_range(0, NRET - 1);
        if (e == 0) rvfi_valid[ln] = ~rvfi_valid[ln];
        if (e == 1) rvfi_order[ln*OW +: OW] = rvfi_order[ln*OW +: OW] + 8'd1;
        if (e == 2) rvfi_pc_rdata[ln*XLEN +: XLEN] = rvfi_pc_rdata[ln*XLEN +: XLEN] ^ 32'h10;
        step();
    endtask

    initial begin
        int ords[3];
        clear_inputs();
        model_reset();
        #1;
        compare_model();
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(retire_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Clean single-lane stream.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_lane(0, n, 1'b0, 1'b0, 32'(n * 4), 32'(n * 4 + 4));
            step();
        end
        chk("s1_err", 64'(err), 64'd0);
        chk("s1_cnt", 64'(retire_count), 64'd4);
        chk("s1_halted", 64'(halted), 64'd0);

        // Order skip, then later mismatches must not overwrite the first capture.
        do_reset();
        ords = '{0, 1, 3};
        for (int n = 0; n < 3; n++) begin
            set_lane(0, ords[n], 1'b0, 1'b0, 32'(n * 4), 32'(n * 4 + 4));
            step();
        end
        chk("s2_err", 64'(err), 64'd1);
        chk("s2_code", 64'(err_code), 64'd2);
        chk("s2_eorder", 64'(err_order), 64'd2);
        for (int n = 4; n < 6; n++) begin
            set_lane(0, n, 1'b0, 1'b0, 32'((n - 1) * 4), 32'(n * 4));
            step();
        end
        chk("s2_code_kept", 64'(err_code), 64'd2);
        chk("s2_eorder_kept", 64'(err_order), 64'd2);

        // Lane hole, then an intra-cycle PC break.
        do_reset();
        set_lane(1, 0, 1'b0, 1'b0, 32'h0, 32'h4);
        step();
        chk("s3_err", 64'(err), 64'd1);
        chk("s3_code", 64'(err_code), 64'd1);
        chk("s3_cnt", 64'(retire_count), 64'd1);
        chk("s3_eorder", 64'(err_order), 64'd0);
        do_reset();
        set_lane(0, 0, 1'b0, 1'b0, 32'h0FC, 32'h100);
        set_lane(1, 1, 1'b0, 1'b0, 32'h104, 32'h108);
        step();
        chk("s3_pc_code", 64'(err_code), 64'd3);
        chk("s3_pc_eorder", 64'(err_order), 64'd1);

        // Trap target is unchecked, the instruction after it is.
        do_reset();
        set_lane(0, 0, 1'b1, 1'b0, 32'h20, 32'h24);
        step();
        set_lane(0, 1, 1'b0, 1'b0, 32'h80, 32'h84);
        step();
        chk("s4_trap_ok", 64'(err), 64'd0);
        set_lane(0, 2, 1'b0, 1'b0, 32'h90, 32'h94);
        step();
        chk("s4_code", 64'(err_code), 64'd3);
        chk("s4_eorder", 64'(err_order), 64'd2);

        // Retire after a halt in the same cycle, then an asynchronous reset between edges.
        do_reset();
        set_lane(0, 0, 1'b0, 1'b1, 32'h0, 32'h4);
        set_lane(1, 1, 1'b0, 1'b0, 32'h4, 32'h8);
        step();
        chk("s5_halted", 64'(halted), 64'd1);
        chk("s5_code", 64'(err_code), 64'd4);
        chk("s5_eorder", 64'(err_order), 64'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("s5_rst_err", 64'(err), 64'd0);
        chk("s5_rst_code", 64'(err_code), 64'd0);
        chk("s5_rst_eorder", 64'(err_order), 64'd0);
        chk("s5_rst_cnt", 64'(retire_count), 64'd0);
        chk("s5_rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        set_lane(0, 0, 1'b0, 1'b0, 32'h40, 32'h44);
        step();
        chk("s5_after_err", 64'(err), 64'd0);
        chk("s5_after_cnt", 64'(retire_count), 64'd1);

        // Counter saturation and order wrap.
        do_reset();
        for (int n = 0; n < 20; n++) legal_cycle(1);
        chk("s6_sat", 64'(retire_count), 64'd15);
        do_reset();
        for (int n = 0; n < 300; n++) legal_cycle(1);
        chk("s6_wrap_err", 64'(err), 64'd0);
        for (int n = 0; n < 100; n++) legal_cycle($urandom_range(0, NRET));
        chk("s6_multi_err", 64'(err), 64'd0);

        // Randomized streams with periodic resets.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            else random_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
